exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Precise-exception controller that sits between the pipeline commit point (MEM stage) and the cp0 register file. It accepts one committing instruction at a time and resolves the pending interrupt and exception sources on it by priority. It then drives the cp0 exception-entry and `eret` strobes for exactly one accepted cycle, and issues a flush plus a redirect PC to the fetch unit over a valid/ack handshake. It is the only block allowed to assert cp0 `en_exp` / `clean_exl`.

## Interface
- `RESET_VEC`, 32'hBFC0_0000, boot ROM base used when BEV=1
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-low
- `stall`  in  1  global run enable; 1 = run, 0 = halt (freeze all state)
- `commit_valid`  in  1  MEM stage presents an instruction
- `commit_ready`  out  1  controller can accept a commit
- `commit_pc`  in  32  PC of the committing instruction
- `commit_bd`  in  1  instruction is in a branch delay slot
- `commit_exc`  in  7  flags: [0] AdEL-fetch, [1] RI, [2] Sys, [3] Bp, [4] Ov, [5] AdEL-data, [6] AdES
- `commit_eret`  in  1  instruction is ERET
- `commit_badva`  in  32  faulting data address; fetch faults use `commit_pc`
- `allow_int`, `int_exl`, `boot_exp_vec`, `special_int_vec`  in  1 each  from cp0
- `interrupt_mask`  in  8  cp0 Status.IM
- `hardware_int`  in  6  cp0 Cause.IP[7:2]
- `software_int`  in  2  cp0 Cause.IP[1:0]
- `ebase`  in  20  cp0 exception base, bits [31:12]
- `epc`  in  32  cp0 EPC
- `en_exp`, `clean_exl`, `exp_bd`, `exp_badv_we`  out  1 each  to cp0
- `exp_code`  out  5  to cp0
- `exp_epc`, `exp_bad_vaddr`  out  32  to cp0
- `flush`  out  1  kill IF..MEM stages
- `redirect_valid`  out  1  new PC available
- `redirect_pc`  out  32  target PC
- `redirect_ack`  in  1  fetch accepted the redirect

## Operation
- **Interrupt pending:** `int_req = allow_int & |({hardware_int,software_int} & interrupt_mask)`. It is sampled only on an accepted commit.
- **Trigger:** a commit is accepted when `commit_valid & commit_ready & stall`. If the accepted commit has `int_req`, any `commit_exc` bit, or `commit_eret` set, latch the cause and go to TRAP. Otherwise the commit retires normally and the FSM stays in IDLE.
- **Priority, highest first:** Int(0) > AdEL-fetch(4) > RI(10) > Sys(8) > Bp(9) > Ov(12) > AdEL-data(4) > AdES(5) > ERET. The first match wins; lower sources are discarded.
- **Latched EPC:** `exp_epc = commit_bd ? commit_pc-4 : commit_pc`; `exp_bd = commit_bd`.
- **Bad address:**
  - AdEL-fetch: `exp_bad_vaddr = commit_pc`, `exp_badv_we = 1`.
  - AdEL-data / AdES: `exp_bad_vaddr = commit_badva`, `exp_badv_we = 1`.
  - All other causes: `exp_badv_we = 0`.
- **Vector selection:**
  - BEV=1: `RESET_VEC + 0x380`, or `+0x400` for Int when `special_int_vec`.
  - BEV=0: `{ebase,12'h180}`, or `{ebase,12'h200}` for Int when `special_int_vec`.
  - ERET: target = `epc` sampled during the TRAP cycle.
- **FSM:** IDLE → TRAP → REDIR → IDLE.
  - IDLE: `commit_ready = 1`; all strobes 0.
  - TRAP (one `stall`-high cycle): `flush = 1`. Asserts `en_exp` (exception/Int) or `clean_exl` (ERET), never both. Computes and registers `redirect_pc`.
  - REDIR: `redirect_valid = 1` until `redirect_ack` is seen with `stall = 1`, then IDLE. `commit_ready = 0` in TRAP and REDIR.
- **Halt:** `stall = 0` freezes the state and every register; outputs hold their values. cp0 ignores strobes while `stall = 0`, so TRAP re-presents the same strobe once `stall` returns to 1.
- **Reset mid-operation:** `rst = 0` forces IDLE regardless of state or `stall`.

## Timing
- **Reset values:**
  - `commit_ready = 1`.
  - `en_exp`, `clean_exl`, `flush`, `redirect_valid`, `exp_bd`, `exp_badv_we` = 0.
  - `exp_code = 0`; `exp_epc`, `exp_bad_vaddr`, `redirect_pc` = 0.
- **Cycle latency:** accept at edge N → TRAP strobes valid during cycle N+1 (registered outputs, sampled by cp0 at edge N+2) → `redirect_valid` high from cycle N+2.
- **ERET:** `epc` is read in TRAP, the same cycle `clean_exl` is asserted.
- **Back-to-back:** the next commit can be accepted no earlier than the cycle after the redirect ack.
- **Ack in same cycle:** `redirect_ack` arriving in the first REDIR cycle → IDLE on the next edge (minimum 3-cycle trap).
- **Int and exception on the same commit:** Int wins, code 0; `exp_epc` is still the instruction PC.

## Test plan
- **Syscall:** Sys at `commit_pc=0x8000_1000`, BEV=0, `ebase=0x80000` → `en_exp` one cycle, `exp_code=8`, `exp_epc=0x8000_1000`, `redirect_pc=0x8000_0180`.
- **Delay-slot data fault:** AdES in a delay slot, `pc=0x8000_2004`, `badva=0x0000_0003` → `exp_bd=1`, `exp_epc=0x8000_2000`, `exp_code=5`, `exp_badv_we=1`, `exp_bad_vaddr=3`.
- **Interrupt beats exception:** `hardware_int[5]=1`, IM7=1, `allow_int=1`, with Ov on the same commit → `exp_code=0`. BEV=1 and `special_int_vec=1` → `redirect_pc=0xBFC0_0400`.
- **ERET:** ERET with `epc=0x8000_3000` → `clean_exl=1`, `en_exp=0`, `redirect_pc=0x8000_3000`.
- **Halt in TRAP:** drop `stall` for 3 cycles while in TRAP → state and strobes hold; `en_exp` effective exactly once after `stall` returns; `redirect_ack` is delayed 4 cycles and `redirect_valid` holds throughout.
- **Reset mid-operation:** `rst = 0` while in REDIR → next cycle `commit_ready=1`, `redirect_valid=0`, `flush=0`.

Source files
------------

// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - commit and redirect handshake bundle for exc_ctrl
interface exc_ctrl_if;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic [6:0]  commit_exc;
  logic        commit_eret;
  logic [31:0] commit_badva;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ack;

  // pipeline / fetch side
  modport master (
    output commit_valid, commit_pc, commit_bd, commit_exc, commit_eret, commit_badva, redirect_ack,
    input  commit_ready, flush, redirect_valid, redirect_pc
  );

  // exception controller side
  modport slave (
    input  commit_valid, commit_pc, commit_bd, commit_exc, commit_eret, commit_badva, redirect_ack,
    output commit_ready, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - precise exception / eret controller between commit point and cp0
module exc_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'hBFC0_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  exc_ctrl_if.slave        bus,
  input  logic             allow_int,
  input  logic             int_exl,
  input  logic             boot_exp_vec,
  input  logic             special_int_vec,
  input  logic [7:0]       interrupt_mask,
  input  logic [5:0]       hardware_int,
  input  logic [1:0]       software_int,
  input  logic [19:0]      ebase,
  input  logic [31:0]      epc,
  output logic             en_exp,
  output logic             clean_exl,
  output logic             exp_bd,
  output logic             exp_badv_we,
  output logic [4:0]       exp_code,
  output logic [31:0]      exp_epc,
  output logic [31:0]      exp_bad_vaddr
);

  typedef enum logic [1:0] {IDLE, TRAP, REDIR} state_t;

  state_t      state, state_n;
  logic        accept;
  logic        int_req;
  logic        trig;
  logic [4:0]  code_d;
  logic        badv_we_d;
  logic [31:0] badv_d;
  logic        eret_d;
  logic        int_q;
  logic        eret_q;
  logic [31:0] target;
  logic [31:0] redirect_q;

  // EXL gating is already folded into allow_int by cp0
  logic unused;
  assign unused = int_exl;

  assign accept = bus.commit_valid & bus.commit_ready & stall;

  // priority resolution of the committing instruction's trap sources
  always_comb begin
    int_req   = allow_int & |({hardware_int, software_int} & interrupt_mask);
    trig      = 1'b1;
    code_d    = 5'd0;
    badv_we_d = 1'b0;
    badv_d    = 32'd0;
    eret_d    = 1'b0;
    if (int_req) begin
      code_d = 5'd0;
    end else if (bus.commit_exc[0]) begin
      code_d    = 5'd4;
      badv_we_d = 1'b1;
      badv_d    = bus.commit_pc;
    end else if (bus.commit_exc[1]) begin
      code_d = 5'd10;
    end else if (bus.commit_exc[2]) begin
      code_d = 5'd8;
    end else if (bus.commit_exc[3]) begin
      code_d = 5'd9;
    end else if (bus.commit_exc[4]) begin
      code_d = 5'd12;
    end else if (bus.commit_exc[5]) begin
      code_d    = 5'd4;
      badv_we_d = 1'b1;
      badv_d    = bus.commit_badva;
    end else if (bus.commit_exc[6]) begin
      code_d    = 5'd5;
      badv_we_d = 1'b1;
      badv_d    = bus.commit_badva;
    end else if (bus.commit_eret) begin
      eret_d = 1'b1;
    end else begin
      trig = 1'b0;
    end
  end

  // state register; a low stall freezes the FSM, reset always wins
  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else if (stall)
      state <= state_n;
  end

  // next-state and handshake/strobe outputs
  always_comb begin
    state_n            = state;
    bus.commit_ready   = 1'b0;
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    en_exp             = 1'b0;
    clean_exl          = 1'b0;
    case (state)
      IDLE: begin
        bus.commit_ready = 1'b1;
        if (accept && trig)
          state_n = TRAP;
      end
      TRAP: begin
        bus.flush = 1'b1;
        en_exp    = ~eret_q;
        clean_exl = eret_q;
        state_n   = REDIR;
      end
      REDIR: begin
        bus.redirect_valid = 1'b1;
        if (bus.redirect_ack)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // redirect target; epc and the vector inputs are read while in TRAP
  always_comb begin
    if (eret_q)
      target = epc;
    else if (boot_exp_vec)
      target = RESET_VEC + ((int_q && special_int_vec) ? 32'h400 : 32'h380);
    else
      target = {ebase, ((int_q && special_int_vec) ? 12'h200 : 12'h180)};
  end

  // cause latch on the accepted commit, redirect PC registered out of TRAP
  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_code      <= 5'd0;
      exp_epc       <= 32'd0;
      exp_bd        <= 1'b0;
      exp_badv_we   <= 1'b0;
      exp_bad_vaddr <= 32'd0;
      int_q         <= 1'b0;
      eret_q        <= 1'b0;
      redirect_q    <= 32'd0;
    end else if (stall) begin
      if (accept && trig) begin
        exp_code    <= code_d;
        exp_epc     <= bus.commit_bd ? bus.commit_pc - 32'd4 : bus.commit_pc;
        exp_bd      <= bus.commit_bd;
        exp_badv_we <= badv_we_d;
        if (badv_we_d)
          exp_bad_vaddr <= badv_d;
        int_q  <= int_req;
        eret_q <= eret_d;
      end
      if (state == TRAP)
        redirect_q <= target;
    end
  end

  assign bus.redirect_pc = redirect_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl
module tb_exc_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b1;
  logic        allow_int = 1'b0, int_exl = 1'b0, boot_exp_vec = 1'b0, special_int_vec = 1'b0;
  logic [7:0]  interrupt_mask = 8'h00;
  logic [5:0]  hardware_int = 6'h00;
  logic [1:0]  software_int = 2'b00;
  logic [19:0] ebase = 20'h80000;
  logic [31:0] epc = 32'h0;
  logic        en_exp, clean_exl, exp_bd, exp_badv_we;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc, exp_bad_vaddr;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;

  exc_ctrl_if bus();

  exc_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .bus(bus),
    .allow_int(allow_int), .int_exl(int_exl), .boot_exp_vec(boot_exp_vec),
    .special_int_vec(special_int_vec), .interrupt_mask(interrupt_mask),
    .hardware_int(hardware_int), .software_int(software_int), .ebase(ebase), .epc(epc),
    .en_exp(en_exp), .clean_exl(clean_exl), .exp_bd(exp_bd), .exp_badv_we(exp_badv_we),
    .exp_code(exp_code), .exp_epc(exp_epc), .exp_bad_vaddr(exp_bad_vaddr)
  );

  always #5 clk = ~clk;

  // en_exp strobes that cp0 actually takes (stall high at the edge)
  always @(posedge clk) if (rst && stall && en_exp) en_cnt <= en_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_commit(input logic [31:0] pc, input logic bd, input logic [6:0] exc,
                           input logic eret, input logic [31:0] badva);
    @(negedge clk);
    bus.commit_valid = 1'b1;
    bus.commit_pc    = pc;
    bus.commit_bd    = bd;
    bus.commit_exc   = exc;
    bus.commit_eret  = eret;
    bus.commit_badva = badva;
    @(negedge clk);
    bus.commit_valid = 1'b0;
    bus.commit_exc   = 7'd0;
    bus.commit_eret  = 1'b0;
  endtask

  task automatic trap_case(input string tag, input logic [31:0] pc, input logic bd,
                           input logic [6:0] exc, input logic eret, input logic [31:0] badva,
                           input logic [4:0] e_code, input logic [31:0] e_epc,
                           input logic e_we, input logic [31:0] e_badv, input logic [31:0] e_rpc);
    int c0;
    c0 = en_cnt;
    do_commit(pc, bd, exc, eret, badva);
    check({tag, ".flush"}, bus.flush, 1'b1);
    check({tag, ".ready"}, bus.commit_ready, 1'b0);
    check({tag, ".en_exp"}, en_exp, !eret);
    check({tag, ".clean_exl"}, clean_exl, eret);
    if (!eret) begin
      check({tag, ".code"}, exp_code, e_code);
      check({tag, ".epc"}, exp_epc, e_epc);
      check({tag, ".bd"}, exp_bd, bd);
      check({tag, ".badv_we"}, exp_badv_we, e_we);
      if (e_we) check({tag, ".badv"}, exp_bad_vaddr, e_badv);
    end
    @(negedge clk);
    check({tag, ".rvalid"}, bus.redirect_valid, 1'b1);
    check({tag, ".rpc"}, bus.redirect_pc, e_rpc);
    check({tag, ".strobe_off"}, {en_exp, clean_exl, bus.flush}, 3'b000);
    bus.redirect_ack = 1'b1;
    @(negedge clk);
    bus.redirect_ack = 1'b0;
    check({tag, ".rvalid_done"}, bus.redirect_valid, 1'b0);
    check({tag, ".ready_done"}, bus.commit_ready, 1'b1);
    check({tag, ".en_count"}, en_cnt - c0, eret ? 0 : 1);
  endtask

  initial begin
    bus.commit_valid = 1'b0; bus.commit_pc = 32'd0; bus.commit_bd = 1'b0;
    bus.commit_exc = 7'd0; bus.commit_eret = 1'b0; bus.commit_badva = 32'd0;
    bus.redirect_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.ready", bus.commit_ready, 1'b1);
    check("rst.strobes", {en_exp, clean_exl, bus.flush, bus.redirect_valid, exp_bd, exp_badv_we}, 6'd0);
    check("rst.code", exp_code, 5'd0);
    check("rst.epc", exp_epc, 32'd0);
    check("rst.badv", exp_bad_vaddr, 32'd0);
    check("rst.rpc", bus.redirect_pc, 32'd0);
    rst = 1'b1;

    // plain retire: no trap
    do_commit(32'h8000_0100, 1'b0, 7'd0, 1'b0, 32'd0);
    check("retire.ready", bus.commit_ready, 1'b1);
    check("retire.flush", bus.flush, 1'b0);

    // commit offered while halted is not accepted
    stall = 1'b0;
    do_commit(32'h8000_0200, 1'b0, 7'b0000100, 1'b0, 32'd0);
    stall = 1'b1;
    @(negedge clk);
    check("halted_commit.flush", bus.flush, 1'b0);
    check("halted_commit.ready", bus.commit_ready, 1'b1);

    trap_case("sys", 32'h8000_1000, 1'b0, 7'b0000100, 1'b0, 32'd0,
              5'd8, 32'h8000_1000, 1'b0, 32'd0, 32'h8000_0180);
    trap_case("ades_bd", 32'h8000_2004, 1'b1, 7'b1000000, 1'b0, 32'h0000_0003,
              5'd5, 32'h8000_2000, 1'b1, 32'h0000_0003, 32'h8000_0180);
    trap_case("adel_f", 32'h8000_4000, 1'b0, 7'b0000011, 1'b0, 32'h1234_5678,
              5'd4, 32'h8000_4000, 1'b1, 32'h8000_4000, 32'h8000_0180);
    trap_case("bp_ov", 32'h8000_4100, 1'b0, 7'b0011000, 1'b0, 32'd0,
              5'd9, 32'h8000_4100, 1'b0, 32'd0, 32'h8000_0180);

    allow_int = 1'b1; interrupt_mask = 8'h80; hardware_int = 6'b100000;
    boot_exp_vec = 1'b1; special_int_vec = 1'b1;
    trap_case("int_ov", 32'h8000_5008, 1'b0, 7'b0010000, 1'b0, 32'd0,
              5'd0, 32'h8000_5008, 1'b0, 32'd0, 32'hBFC0_0400);
    // non-interrupt under BEV=1 uses the general vector
    allow_int = 1'b0;
    trap_case("ri_bev", 32'h8000_5100, 1'b0, 7'b0000010, 1'b0, 32'd0,
              5'd10, 32'h8000_5100, 1'b0, 32'd0, 32'hBFC0_0380);
    boot_exp_vec = 1'b0; special_int_vec = 1'b0; hardware_int = 6'd0; interrupt_mask = 8'h00;

    epc = 32'h8000_3000;
    trap_case("eret", 32'h8000_6000, 1'b0, 7'd0, 1'b1, 32'd0,
              5'd0, 32'd0, 1'b0, 32'd0, 32'h8000_3000);

    // halt while in TRAP, then delayed ack
    begin
      int c0;
      c0 = en_cnt;
      do_commit(32'h8000_7000, 1'b0, 7'b0000100, 1'b0, 32'd0);
      stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("halt.flush", bus.flush, 1'b1);
        check("halt.en_exp", en_exp, 1'b1);
        check("halt.rvalid", bus.redirect_valid, 1'b0);
      end
      stall = 1'b1;
      @(negedge clk);
      check("halt.en_once", en_cnt - c0, 1);
      check("halt.rpc", bus.redirect_pc, 32'h8000_0180);
      for (int i = 0; i < 4; i++) begin
        check("halt.rvalid_hold", bus.redirect_valid, 1'b1);
        @(negedge clk);
      end
      stall = 1'b0;
      bus.redirect_ack = 1'b1;
      @(negedge clk);
      check("halt.ack_ignored", bus.redirect_valid, 1'b1);
      stall = 1'b1;
      @(negedge clk);
      bus.redirect_ack = 1'b0;
      check("halt.done", bus.commit_ready, 1'b1);
      check("halt.en_total", en_cnt - c0, 1);
    end

    // reset while in REDIR
    do_commit(32'h8000_8000, 1'b0, 7'b0001000, 1'b0, 32'd0);
    @(negedge clk);
    check("mid_rst.in_redir", bus.redirect_valid, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst.ready", bus.commit_ready, 1'b1);
    check("mid_rst.rvalid", bus.redirect_valid, 1'b0);
    check("mid_rst.flush", bus.flush, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
